// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared FSM encoding, funct3/LdSel codes and decode helpers
package lsu_ctrl_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [2:0]  f3;
        logic [1:0]  off;
    } req_t;

    function automatic logic [2:0] ld_sel_of(input logic [2:0] f3);
        ld_sel_of = (f3 == F3_H)  ? LD_H  :
                    (f3 == F3_W)  ? LD_W  :
                    (f3 == F3_BU) ? LD_BU :
                    (f3 == F3_HU) ? LD_HU : LD_B;
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (!we && ((f3 == F3_BU) || (f3 == F3_HU)));
    endfunction

endpackage

// File: rtl/lsu_ctrl_st_align.sv
// st_align: places store data and byte mask on the addressed word lanes
module st_align
    import lsu_ctrl_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o
);

    // loads drive no lanes; stores shift mask and data by the byte offset
    always_comb begin
        wmask_o = !we_i               ? 4'b0000 :
                  (funct3_i == F3_B)  ? 4'b0001 << off_i :
                  (funct3_i == F3_H)  ? 4'b0011 << off_i : 4'b1111;
        wdata_o = we_i ? wdata_i << {off_i, 3'b000} : 32'h0;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller between pipeline and dmem
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [2:0]  resp_ld_sel,
    output logic [1:0]  resp_shamt,
    output logic        resp_fault,
    output logic        stall
);

    logic [1:0]  state_q, state_d;
    req_t        req_q, req_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [2:0]  resp_ld_sel_q, resp_ld_sel_d;
    logic [1:0]  resp_shamt_q, resp_shamt_d;
    logic        resp_fault_q, resp_fault_d;
    logic [3:0]  al_wmask;
    logic [31:0] al_wdata;
    logic        accept, dec_fault, fa, active, done, timeout;

    st_align u_st_align (
        .we_i     (req_we),
        .funct3_i (req_funct3),
        .off_i    (req_addr[1:0]),
        .wdata_i  (req_wdata),
        .wmask_o  (al_wmask),
        .wdata_o  (al_wdata)
    );

    // decode, FSM transitions, timeout counter and response capture
    always_comb begin
        accept    = req_valid && (state_q == S_IDLE);
        dec_fault = !f3_legal(req_we, req_funct3) ||
                    ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00)) ||
                    (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && (req_addr[1:0] == 2'b11));
        fa        = accept && dec_fault;
        active    = (state_q == S_ISSUE) || (state_q == S_WAIT);
        done      = ((state_q == S_ISSUE) && mem_ready && mem_rvalid) ||
                    ((state_q == S_WAIT) && mem_rvalid);
        timeout   = active && !done && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
        state_d   = accept ? (dec_fault ? S_RESP : S_ISSUE) :
                    (done || timeout) ? S_RESP :
                    ((state_q == S_ISSUE) && mem_ready) ? S_WAIT :
                    (state_q == S_RESP) ? S_IDLE : state_q;
        req_d     = accept ? '{addr: {req_addr[31:2], 2'b00}, we: req_we, f3: req_funct3, off: req_addr[1:0]} : req_q;
        wdata_d   = accept ? al_wdata : wdata_q;
        wmask_d   = accept ? al_wmask : wmask_q;
        cnt_d     = accept ? 8'd0 : active ? cnt_q + 8'd1 : cnt_q;
        resp_fault_d  = (fa || timeout) ? 1'b1 : done ? 1'b0 : resp_fault_q;
        resp_ld_sel_d = done ? (req_q.we ? LD_B : ld_sel_of(req_q.f3)) :
                        (fa || timeout) ? LD_B : resp_ld_sel_q;
        resp_rdata_d  = done ? (req_q.we ? 32'h0 : mem_rdata) :
                        (fa || timeout) ? 32'h0 : resp_rdata_q;
        resp_shamt_d  = fa ? req_addr[1:0] : (done || timeout) ? req_q.off : resp_shamt_q;
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            req_q         <= '0;
            wdata_q       <= '0;
            wmask_q       <= '0;
            cnt_q         <= '0;
            resp_rdata_q  <= '0;
            resp_ld_sel_q <= '0;
            resp_shamt_q  <= '0;
            resp_fault_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            wdata_q       <= wdata_d;
            wmask_q       <= wmask_d;
            cnt_q         <= cnt_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_ld_sel_q <= resp_ld_sel_d;
            resp_shamt_q  <= resp_shamt_d;
            resp_fault_q  <= resp_fault_d;
        end
    end

    assign req_ready   = state_q == S_IDLE;
    assign stall       = state_q != S_IDLE;
    assign mem_valid   = state_q == S_ISSUE;
    assign mem_addr    = req_q.addr;
    assign mem_we      = mem_valid && req_q.we;
    assign mem_wmask   = mem_valid ? wmask_q : 4'b0000;
    assign mem_wdata   = wdata_q;
    assign resp_valid  = state_q == S_RESP;
    assign resp_rdata  = resp_rdata_q;
    assign resp_ld_sel = resp_ld_sel_q;
    assign resp_shamt  = resp_shamt_q;
    assign resp_fault  = resp_fault_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: table-driven and sequence checks of lsu_ctrl with a response scoreboard
module tb_lsu_ctrl;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
        logic [2:0]  ld_sel;
        logic [3:0]  wmask;
        logic [31:0] mwdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [2:0]  ld_sel;
        logic [1:0]  shamt;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, t_req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic        t_mem_ready = 1'b0, t_mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    logic        req_ready, mem_valid, mem_we, resp_valid, resp_fault, stall;
    logic [31:0] mem_addr, mem_wdata, resp_rdata;
    logic [3:0]  mem_wmask;
    logic [2:0]  resp_ld_sel;
    logic [1:0]  resp_shamt;

    logic        t_req_ready, t_mem_valid, t_mem_we, t_resp_valid, t_resp_fault, t_stall;
    logic [31:0] t_mem_addr, t_mem_wdata, t_resp_rdata;
    logic [3:0]  t_mem_wmask;
    logic [2:0]  t_resp_ld_sel;
    logic [1:0]  t_resp_shamt;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t tbl[17];

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_ld_sel(resp_ld_sel),
        .resp_shamt(resp_shamt), .resp_fault(resp_fault), .stall(stall)
    );

    lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst(rst), .req_valid(t_req_valid), .req_ready(t_req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_valid(t_mem_valid), .mem_ready(t_mem_ready), .mem_addr(t_mem_addr), .mem_we(t_mem_we),
        .mem_wmask(t_mem_wmask), .mem_wdata(t_mem_wdata), .mem_rvalid(t_mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(t_resp_valid), .resp_rdata(t_resp_rdata), .resp_ld_sel(t_resp_ld_sel),
        .resp_shamt(t_resp_shamt), .resp_fault(t_resp_fault), .stall(t_stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: every response pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected got=1 want=0 t=%0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_ld_sel", 32'(resp_ld_sel), 32'(e.ld_sel));
                chk("resp_shamt", 32'(resp_shamt), 32'(e.shamt));
                chk("resp_fault", 32'(resp_fault), 32'(e.fault));
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int   n;
        logic seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = v.rdata;
        sb.push_back('{rdata: v.exp_rdata, ld_sel: v.ld_sel, shamt: v.addr[1:0], fault: v.fault});
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        seen = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (mem_valid) begin
                seen = 1'b1;
                chk("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
                chk("mem_we", 32'(mem_we), 32'(v.we));
                chk("mem_wmask", 32'(mem_wmask), 32'(v.wmask));
                if (v.we) chk("mem_wdata", mem_wdata, v.mwdata);
            end
        end while (!resp_valid && n < 10);
        chk("latency", 32'(n), v.fault ? 32'd1 : 32'd2);
        chk("mem_issued", 32'(seen), 32'(!v.fault));
        @(negedge clk);
        chk("resp_pulse_end", 32'(resp_valid), 32'd0);
        chk("hold_rdata", resp_rdata, v.exp_rdata);
        chk("hold_fault", 32'(resp_fault), 32'(v.fault));
        chk("ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 3'b010, 4'b0000, 32'h0,        32'hDEADBEEF};
        tbl[1]  = '{1'b1, 3'b000, 32'h203, 32'h000000AB, 32'h77777777, 1'b0, 3'b000, 4'b1000, 32'hAB000000, 32'h0};
        tbl[2]  = '{1'b0, 3'b000, 32'h101, 32'h0,        32'h11223344, 1'b0, 3'b000, 4'b0000, 32'h0,        32'h11223344};
        tbl[3]  = '{1'b0, 3'b100, 32'h102, 32'h0,        32'h55667788, 1'b0, 3'b011, 4'b0000, 32'h0,        32'h55667788};
        tbl[4]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h99AABBCC, 1'b0, 3'b001, 4'b0000, 32'h0,        32'h99AABBCC};
        tbl[5]  = '{1'b0, 3'b101, 32'h100, 32'h0,        32'h0BADF00D, 1'b0, 3'b100, 4'b0000, 32'h0,        32'h0BADF00D};
        tbl[6]  = '{1'b1, 3'b001, 32'h202, 32'h00001234, 32'h77777777, 1'b0, 3'b000, 4'b1100, 32'h12340000, 32'h0};
        tbl[7]  = '{1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h77777777, 1'b0, 3'b000, 4'b1111, 32'hCAFEF00D, 32'h0};
        tbl[8]  = '{1'b1, 3'b000, 32'h201, 32'h0000005A, 32'h77777777, 1'b0, 3'b000, 4'b0010, 32'h00005A00, 32'h0};
        tbl[9]  = '{1'b1, 3'b001, 32'h201, 32'h00001234, 32'h77777777, 1'b0, 3'b000, 4'b0110, 32'h00123400, 32'h0};
        tbl[10] = '{1'b0, 3'b001, 32'h103, 32'h0,        32'hFFFFFFFF, 1'b1, 3'b000, 4'b0000, 32'h0,        32'h0};
        tbl[11] = '{1'b0, 3'b011, 32'h100, 32'h0,        32'hFFFFFFFF, 1'b1, 3'b000, 4'b0000, 32'h0,        32'h0};
        tbl[12] = '{1'b0, 3'b010, 32'h102, 32'h0,        32'hFFFFFFFF, 1'b1, 3'b000, 4'b0000, 32'h0,        32'h0};
        tbl[13] = '{1'b1, 3'b010, 32'h201, 32'h12345678, 32'hFFFFFFFF, 1'b1, 3'b000, 4'b0000, 32'h0,        32'h0};
        tbl[14] = '{1'b1, 3'b100, 32'h200, 32'h12345678, 32'hFFFFFFFF, 1'b1, 3'b000, 4'b0000, 32'h0,        32'h0};
        tbl[15] = '{1'b0, 3'b110, 32'h104, 32'h0,        32'hFFFFFFFF, 1'b1, 3'b000, 4'b0000, 32'h0,        32'h0};
        tbl[16] = '{1'b0, 3'b100, 32'h3FF, 32'h0,        32'h01020304, 1'b0, 3'b011, 4'b0000, 32'h0,        32'h01020304};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) run_vec(tbl[i]);

        // reset while a load is waiting for its response
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h500;
        mem_ready = 1'b1; mem_rvalid = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wait_stall", 32'(stall), 32'd1);
        chk("wait_mem_valid", 32'(mem_valid), 32'd0);
        rst = 1'b1; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_mem_valid", 32'(mem_valid), 32'd0);
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_mem_wmask", 32'(mem_wmask), 32'd0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        chk("abort_mem_wdata", mem_wdata, 32'h0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_resp_rdata", resp_rdata, 32'h0);
        chk("abort_resp_ld_sel", 32'(resp_ld_sel), 32'd0);
        chk("abort_resp_shamt", 32'(resp_shamt), 32'd0);
        chk("abort_resp_fault", 32'(resp_fault), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_stall", 32'(stall), 32'd0);
        mem_rvalid = 1'b0;
        run_vec(tbl[0]);

        // store with a slow memory: three refused cycles, then two wait cycles
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h308; req_wdata = 32'h55AA33CC;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h12345678;
        sb.push_back('{rdata: 32'h0, ld_sel: 3'b000, shamt: 2'b00, fault: 1'b0});
        @(posedge clk);
        #1 req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("slow_mem_valid", 32'(mem_valid), 32'd1);
            chk("slow_mem_addr", mem_addr, 32'h308);
            chk("slow_mem_wdata", mem_wdata, 32'h55AA33CC);
            chk("slow_mem_wmask", 32'(mem_wmask), 32'hF);
            chk("slow_mem_we", 32'(mem_we), 32'd1);
            chk("slow_stall", 32'(stall), 32'd1);
            chk("slow_no_resp", 32'(resp_valid), 32'd0);
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            chk("slow_wait_mem_valid", 32'(mem_valid), 32'd0);
            chk("slow_wait_stall", 32'(stall), 32'd1);
            chk("slow_wait_no_resp", 32'(resp_valid), 32'd0);
        end
        mem_rvalid = 1'b1;
        @(negedge clk);
        chk("slow_resp", 32'(resp_valid), 32'd1);
        chk("slow_resp_stall", 32'(stall), 32'd1);
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("slow_resp_end", 32'(resp_valid), 32'd0);
        chk("slow_idle_stall", 32'(stall), 32'd0);

        // timeout instance: memory never answers, then a stray late response
        @(negedge clk);
        t_req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
        @(posedge clk);
        #1 t_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_mem_valid", 32'(t_mem_valid), 32'd1);
            chk("to_no_resp", 32'(t_resp_valid), 32'd0);
            chk("to_stall", 32'(t_stall), 32'd1);
        end
        @(negedge clk);
        chk("to_resp", 32'(t_resp_valid), 32'd1);
        chk("to_fault", 32'(t_resp_fault), 32'd1);
        chk("to_mem_off", 32'(t_mem_valid), 32'd0);
        chk("to_ld_sel", 32'(t_resp_ld_sel), 32'd0);
        t_mem_rvalid = 1'b1;
        @(negedge clk);
        chk("to_stray_no_resp", 32'(t_resp_valid), 32'd0);
        chk("to_idle_stall", 32'(t_stall), 32'd0);
        chk("to_fault_hold", 32'(t_resp_fault), 32'd1);
        @(negedge clk);
        chk("to_stray_no_resp2", 32'(t_resp_valid), 32'd0);
        chk("to_ready", 32'(t_req_ready), 32'd1);
        t_mem_rvalid = 1'b0;

        @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles from accept to mem_rvalid before fault (range 1..255).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  pipeline presents load/store request.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_funct3  input  3  RISC-V width/sign field.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, LSB-aligned.
REQ-010 mem_valid  output  1  dmem request valid.
REQ-011 mem_ready  input  1  dmem accepts request.
REQ-012 mem_addr  output  32  word address, {req_addr[31:2],2'b00}.
REQ-013 mem_we / mem_wmask / mem_wdata  output  1/4/32  write enable, byte mask, lane-shifted store data.
REQ-014 mem_rvalid / mem_rdata  input  1/32  dmem response (also store ack); raw word.
REQ-015 resp_valid  output  1  one-cycle completion pulse.
REQ-016 resp_rdata / resp_ld_sel / resp_shamt  output  32/3/2  raw word, LdSel code, byte offset for the writeback load extractor.
REQ-017 resp_fault  output  1  misaligned, illegal funct3 or timeout; valid with resp_valid.
REQ-018 stall  output  1  pipeline hold; high whenever state != IDLE.

Function
REQ-019 The FSM SHALL use states IDLE, ISSUE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-020 Accept on req_valid&req_ready; addr, we, funct3, offset (addr[1:0]) and shifted wdata SHALL be registered at accept.
REQ-021 Legal loads funct3 000,001,010,100,101; legal stores 000,001,010; others SHALL fault.
REQ-022 Misaligned: word with offset!=0, halfword with offset==2'b11; SHALL fault.
REQ-023 Faulting request: IDLE->RESP, no mem_valid ever asserted, resp_fault=1.
REQ-024 Legal request: IDLE->ISSUE; mem_valid=1 and mem_* stable until mem_ready; ISSUE->WAIT on mem_ready.
REQ-025 mem_ready and mem_rvalid in the same ISSUE cycle SHALL go directly to RESP.
REQ-026 WAIT->RESP on mem_rvalid; resp_rdata captures mem_rdata (stores: resp_rdata=0).
REQ-027 RESP lasts exactly one cycle: resp_valid=1, then ->IDLE; min load latency accept-to-resp_valid = 2 cycles with zero-wait memory.
REQ-028 LdSel mapping: LB->000, LH->001, LW->010, LBU->011, LHU->100; stores and faults drive 000.
REQ-029 resp_shamt SHALL equal registered offset.
REQ-030 Store mask: SB 4'b0001<<off, SH 4'b0011<<off, SW 4'b1111; mem_wdata = wdata<<(8*off); loads mem_wmask=0, mem_we=0.
REQ-031 8-bit timeout counter SHALL clear at accept, increment each cycle in ISSUE/WAIT; reaching TIMEOUT_CYCLES SHALL force RESP with fault, mem_valid deasserted.
REQ-032 mem_rvalid outside ISSUE/WAIT SHALL be ignored (late responses after timeout/reset dropped).
REQ-033 Outputs resp_rdata/ld_sel/shamt/fault SHALL hold their value outside RESP (only resp_valid qualifies).

Reset
REQ-034 On rst: state IDLE, req_ready=1, stall=0, mem_valid=0, mem_we=0, mem_wmask=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_fault=0, resp_rdata=0, resp_ld_sel=0, resp_shamt=0, counter=0.
REQ-035 rst asserted mid-transaction SHALL abort it with no resp_valid; the next edge after rst deasserts is IDLE.

Structure
REQ-036 FSM state encoding, LdSel codes and funct3 constants SHALL live in a shared package used by the load extractor and decoder.
REQ-037 One sub-module, st_align (combinational mask/data lane shifter), SHALL be instantiated; everything else in lsu_ctrl.

Verification
REQ-038 LW addr 0x100, zero-wait mem returns 0xDEADBEEF -> resp_valid 2 cycles after accept, rdata 0xDEADBEEF, ld_sel 010, shamt 00, fault 0.
REQ-039 SB addr 0x203, wdata 0x000000AB -> mem_addr 0x200, wmask 1000, wdata 0xAB000000, mem_we 1.
REQ-040 LH addr 0x103 -> resp_fault=1 one cycle after accept, mem_valid never high; funct3 011 load -> same.
REQ-041 mem_ready held low 3 cycles then rvalid 2 cycles later -> mem_* stable throughout, stall high until RESP, single resp_valid pulse.
REQ-042 TIMEOUT_CYCLES=4, mem never responds -> resp_fault after 4 cycles in ISSUE/WAIT; subsequent stray mem_rvalid ignored.
REQ-043 rst pulsed during WAIT -> no resp_valid, all outputs at reset values, next request accepted normally.
